// File: rtl/shift_ctrl_pkg.sv
// Shared types for the multi-cycle shifter controller.
// Optional rotate support is enabled with SHIFT_CTRL_ROTATE_EN.
package shift_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_LSL  = 3'b010,
        OP_LSR  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROR  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        K_LSL = 2'b00,
        K_LSR = 2'b01,
        K_ASR = 2'b10,
        K_ROR = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    function automatic op_e kind_op(kind_e k);
        op_e op;
        op = OP_NOP;
        unique case (k)
            K_LSL: op = OP_LSL;
            K_LSR: op = OP_LSR;
            K_ASR: op = OP_ASR;
`ifdef SHIFT_CTRL_ROTATE_EN
            K_ROR: op = OP_ROR;
`else
            K_ROR: op = OP_NOP;
`endif
        endcase
        return op;
    endfunction

endpackage

// File: rtl/shift_ctrl_shift_step.sv
// One combinational shift step of up to three bit positions.
// ROR logic exists only when SHIFT_CTRL_ROTATE_EN is defined.
import shift_ctrl_pkg::*;

module shift_step (
    input  op_e        op,
    input  logic [1:0] shamt,
    input  logic [7:0] d_in,
    output logic [7:0] d_out
);

    always_comb begin
        d_out = d_in;
        case (op)
            OP_LSL: d_out = d_in << shamt;
            OP_LSR: d_out = d_in >> shamt;
            OP_ASR: d_out = unsigned'($signed(d_in) >>> shamt);
`ifdef SHIFT_CTRL_ROTATE_EN
            OP_ROR: d_out = (d_in >> shamt)
                          | (d_in << (4'd8 - {2'b00, shamt}));
`endif
            default: d_out = d_in;
        endcase
    end

endmodule

// File: rtl/shift_ctrl.sv
// Handshaked shifter: a job is split into steps of at most STEP_MAX bits.
// Define SHIFT_CTRL_ROTATE_EN to make kind 11 a rotate-right.
import shift_ctrl_pkg::*;

module shift_ctrl #(
    parameter int STEP_MAX = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_kind,
    input  logic [2:0] req_amt,
    input  logic [7:0] req_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] op_o,
    output logic [1:0] shamt_o
);

    localparam logic [2:0] STEP = 3'(STEP_MAX);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [2:0]  amt_q, amt_d;
    logic [7:0]  opnd_q, opnd_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  rem_q, rem_d;
    op_e         op;
    logic [1:0]  step;
    logic [7:0]  shifted;

    shift_step u_step (
        .op    (op),
        .shamt (step),
        .d_in  (data_q),
        .d_out (shifted)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_LSL;
            amt_q   <= '0;
            opnd_q  <= '0;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            amt_q   <= amt_d;
            opnd_q  <= opnd_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        amt_d     = amt_q;
        opnd_d    = opnd_q;
        data_d    = data_q;
        rem_d     = rem_q;
        op        = OP_NOP;
        step      = 2'd0;
        req_ready = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = S_LOAD;
                    kind_d  = kind_e'(req_kind);
                    amt_d   = req_amt;
                    opnd_d  = req_data;
`ifndef SHIFT_CTRL_ROTATE_EN
                    // Without rotate hardware kind 11 is a pass-through
                    if (req_kind == K_ROR) amt_d = 3'd0;
`endif
                end
            end
            S_LOAD: begin
                op      = OP_LOAD;
                data_d  = opnd_q;
                rem_d   = amt_q;
                state_d = (amt_q != 3'd0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                op     = kind_op(kind_q);
                step   = (rem_q > STEP) ? STEP[1:0] : rem_q[1:0];
                data_d = shifted;
                rem_d  = rem_q - {1'b0, step};
                if (rem_d == 3'd0) state_d = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = S_IDLE;
            end
        endcase
    end

    assign res_data = data_q;
    assign op_o     = op;
    assign shamt_o  = step;

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl against an arithmetic shift model.
// Build with SHIFT_CTRL_ROTATE_EN defined to exercise rotate.
module tb_shift_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic [1:0] req_kind = '0;
    logic [2:0] req_amt = '0;
    logic [7:0] req_data = '0;
    logic       req_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic [2:0] op_o;
    logic [1:0] shamt_o;

    int vec = 0;
    int mis = 0;

    always #5 clk = ~clk;

    shift_ctrl #(.STEP_MAX(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_amt   (req_amt),
        .req_data  (req_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .op_o      (op_o),
        .shamt_o   (shamt_o)
    );

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_amt(int k, int amt);
`ifdef SHIFT_CTRL_ROTATE_EN
        return amt;
`else
        return (k == 3) ? 0 : amt;
`endif
    endfunction

    function automatic logic [7:0] model(int k, int amt, logic [7:0] d);
        int v;
        v = int'(d);
        case (k)
            0: return 8'((v * (1 << amt)) % 256);
            1: return 8'(v / (1 << amt));
            2: begin
                if (v >= 128) v = v - 256;
                return 8'(v >>> amt);
            end
            default: begin
`ifdef SHIFT_CTRL_ROTATE_EN
                return 8'(((v >> amt) | (v << (8 - amt))) % 256);
`else
                return d;
`endif
            end
        endcase
    endfunction

    task automatic run_job(int k, int amt, logic [7:0] d, int hold);
        int rem, cyc, lat, st;
        logic [7:0] exp;
        bit done;
        exp = model(k, amt, d);
        rem = eff_amt(k, amt);
        lat = 2 + (rem + 2) / 3;
        chk("idle_ready", 8'(req_ready), 8'd1);
        chk("idle_op", 8'(op_o), 8'd0);
        chk("idle_shamt", 8'(shamt_o), 8'd0);
        req_valid = 1'b1;
        req_kind = 2'(k);
        req_amt = 3'(amt);
        req_data = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_kind = 2'($urandom);
        req_amt = 3'($urandom);
        req_data = 8'($urandom);
        cyc = 1;
        chk("load_op", 8'(op_o), 8'd1);
        chk("load_ready", 8'(req_ready), 8'd0);
        done = 1'b0;
        while (!done && cyc < 16) begin
            @(posedge clk);
            #1;
            cyc++;
            if (res_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                st = (rem > 3) ? 3 : rem;
                chk("shamt", 8'(shamt_o), 8'(st));
                chk("shift_op", 8'(op_o), 8'(2 + k));
                rem = rem - st;
            end
        end
        chk("latency", 8'(cyc), 8'(lat));
        chk("result", res_data, exp);
        chk("done_op", 8'(op_o), 8'd0);
        chk("done_ready", 8'(req_ready), 8'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 8'(res_valid), 8'd1);
            chk("hold_data", res_data, exp);
            chk("hold_ready", 8'(req_ready), 8'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("back_valid", 8'(res_valid), 8'd0);
        chk("back_ready", 8'(req_ready), 8'd1);
        chk("back_data", res_data, exp);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #12;
        chk("rst_valid", 8'(res_valid), 8'd0);
        chk("rst_data", res_data, 8'd0);
        chk("rst_op", 8'(op_o), 8'd0);
        chk("rst_shamt", 8'(shamt_o), 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 8'(req_ready), 8'd1);

        run_job(0, 5, 8'h81, 0);
        run_job(2, 7, 8'h90, 1);
        run_job(1, 7, 8'h90, 0);
        run_job(0, 0, 8'h5A, 0);
        run_job(1, 3, 8'hC3, 10);
        run_job(3, 3, 8'h01, 0);

        // abort a job in the middle of its shift phase
        req_valid = 1'b1;
        req_kind = 2'd0;
        req_amt = 3'd7;
        req_data = 8'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_op", 8'(op_o), 8'd2);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", 8'(res_valid), 8'd0);
        chk("arst_data", res_data, 8'd0);
        chk("arst_op", 8'(op_o), 8'd0);
        chk("arst_shamt", 8'(shamt_o), 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("no_result", 8'(res_valid), 8'd0);
        end
        run_job(2, 4, 8'hA5, 0);

        repeat (25) begin
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The block SHALL have parameter STEP_MAX, default 3, meaning the maximum bit positions shifted per cycle (legal values 1..3).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the requester offers a shift job.
REQ-005 The block SHALL have port req_ready, output, 1 bit: high only in IDLE; a job is accepted on a cycle where req_valid and req_ready are both high.
REQ-006 The block SHALL have port req_kind, input, 2 bits: 00 LSL, 01 LSR, 10 ASR, 11 ROR (ROR valid only with the macro).
REQ-007 The block SHALL have port req_amt, input, 3 bits: total shift amount, 0..7.
REQ-008 The block SHALL have port req_data, input, 8 bits: the operand.
REQ-009 The block SHALL have port res_valid, output, 1 bit: res_data is valid.
REQ-010 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port res_data, output, 8 bits: the shifted result.
REQ-012 The block SHALL have port op_o, output, 3 bits: the current op code (NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100, ROR 101).
REQ-013 The block SHALL have port shamt_o, output, 2 bits: the step amount issued this cycle.

Function
REQ-014 The FSM SHALL have four states, IDLE, LOAD, SHIFT and DONE, and on acceptance SHALL go IDLE->LOAD, capturing req_kind, req_amt and req_data.
REQ-015 In LOAD, op_o SHALL be LOAD, the data register SHALL take the captured operand, and remaining SHALL be set to req_amt.
REQ-016 LOAD SHALL go to SHIFT if remaining>0, else to DONE.
REQ-017 In SHIFT, each cycle shamt_o SHALL be min(remaining, STEP_MAX), op_o SHALL be the kind's code, the register SHALL take the shifted value, and remaining SHALL decrease by shamt_o.
REQ-018 SHIFT SHALL go to DONE on the cycle remaining reaches 0.
REQ-019 LSL and LSR SHALL fill with 0; ASR SHALL fill with bit 7; ROR SHALL wrap the bits shifted out of bit 0 into bit 7.
REQ-020 Latency from the accept edge to res_valid high SHALL be 2 + ceil(amt/STEP_MAX) cycles (amt=0 gives 2).
REQ-021 In DONE, res_valid SHALL be 1, res_data SHALL hold steady and op_o SHALL be NOP; DONE SHALL go to IDLE on res_ready, and otherwise hold indefinitely.
REQ-022 req_ready SHALL be 0 in DONE, so no job overlaps another.
REQ-023 In IDLE, op_o SHALL be NOP, shamt_o SHALL be 0, and res_data SHALL keep the last result.
REQ-024 Inputs SHALL be ignored outside acceptance, and changes to req_* after acceptance SHALL have no effect on the job in progress.

Reset
REQ-025 Assertion of reset_n low SHALL, immediately and in any state, force IDLE, res_valid=0, res_data=0, op_o=NOP, shamt_o=0 and remaining=0.
REQ-026 A job in progress at reset SHALL be discarded with no result produced.
REQ-027 After deassertion, req_ready SHALL be 1 on the first clock.

Configuration
REQ-028 When macro SHIFT_CTRL_ROTATE_EN is defined, kind 11 SHALL perform ROR with op_o=101.
REQ-029 When SHIFT_CTRL_ROTATE_EN is undefined, kind 11 SHALL be accepted and treated as amt=0, so the result equals the operand after 2 cycles and no ROR hardware exists.

Structure
REQ-030 Package shift_ctrl_pkg SHALL hold the op code constants, the kind encodings and the FSM state type.
REQ-031 A single combinational sub-module shift_step (inputs op, shamt, d_in; output d_out) SHALL implement one step of LSL/LSR/ASR (plus ROR when enabled) and be instantiated once.

Verification
REQ-032 The bench SHALL check: LSL, data 8'h81, amt 5, STEP_MAX 3 -> shamt_o sequence 3, 2; res_data 8'h20; res_valid 4 cycles after accept.
REQ-033 The bench SHALL check: ASR, data 8'h90, amt 7 -> res_data 8'hFF; LSR same operand -> 8'h01.
REQ-034 The bench SHALL check: amt 0, data 8'h5A -> no SHIFT cycle; res_data 8'h5A, 2 cycles after accept.
REQ-035 The bench SHALL check: res_ready held low 10 cycles in DONE -> res_valid and res_data stable, req_ready 0; one res_ready pulse -> IDLE on the next cycle.
REQ-036 The bench SHALL check: reset_n pulsed low mid-SHIFT -> outputs zero without waiting for a clock; no res_valid follows; a new job then completes correctly.
REQ-037 The bench SHALL check: ROR, data 8'h01, amt 3, with the macro -> 8'h20; without the macro -> 8'h01.
